// File: rtl/cga_timing_if.sv
// Bundle between the CGA timing generator and the composite encoder stage:
// the upstream IRGB inputs and every timing/video output.
interface cga_timing_if;
  logic [3:0] pixel_in;
  logic [3:0] border_color;
  logic       hclk;
  logic       lclk;
  logic       hsync;
  logic       vsync_l;
  logic       display_en;
  logic [6:0] hcount;
  logic [8:0] vcount;
  logic       frame_start;
  logic [3:0] video;

  modport master (
    input  pixel_in, border_color,
    output hclk, lclk, hsync, vsync_l, display_en, hcount, vcount,
           frame_start, video
  );

  modport slave (
    output pixel_in, border_color,
    input  hclk, lclk, hsync, vsync_l, display_en, hcount, vcount,
           frame_start, video
  );
endinterface

// File: rtl/cga_timing_gen.sv
// CGA raster timing generator: phase/character/line counters, sync and
// display-enable decode, and the IRGB/border/blank video mux, all registered.
module cga_timing_gen #(
  parameter int unsigned H_TOTAL      = 114,
  parameter int unsigned H_DISP       = 80,
  parameter int unsigned H_SYNC_START = 90,
  parameter int unsigned H_SYNC_WIDTH = 10,
  parameter int unsigned V_TOTAL      = 262,
  parameter int unsigned V_DISP       = 200,
  parameter int unsigned V_SYNC_START = 224,
  parameter int unsigned V_SYNC_WIDTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  cga_timing_if.master bus
);

  // Sync windows are compared one bit wider than the counters so that
  // START+WIDTH never truncates.
  localparam logic [6:0] HC_LAST = 7'(H_TOTAL - 1);
  localparam logic [8:0] VC_LAST = 9'(V_TOTAL - 1);
  localparam logic [7:0] HS_LO   = 8'(H_SYNC_START);
  localparam logic [7:0] HS_HI   = 8'(H_SYNC_START + H_SYNC_WIDTH);
  localparam logic [7:0] HD_END  = 8'(H_DISP);
  localparam logic [9:0] VS_LO   = 10'(V_SYNC_START);
  localparam logic [9:0] VS_HI   = 10'(V_SYNC_START + V_SYNC_WIDTH);
  localparam logic [9:0] VD_END  = 10'(V_DISP);

  logic [4:0] ph_q, ph_d;
  logic [6:0] hc_q, hc_d;
  logic [8:0] vc_q, vc_d;

  logic       hclk_q, hclk_d;
  logic       lclk_q, lclk_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       de_q, de_d;
  logic       fs_q, fs_d;
  logic [6:0] hcount_q, hcount_d;
  logic [8:0] vcount_q, vcount_d;
  logic [3:0] video_q, video_d;

  logic       hc_step;
  logic       hc_wrap;
  logic [7:0] hc_w;
  logic [9:0] vc_w;

  always_comb begin
    ph_d    = ph_q + 5'd1;
    hc_step = (ph_q[3:0] == 4'hF);
    hc_wrap = hc_step && (hc_q == HC_LAST);
    hc_d    = hc_q;
    vc_d    = vc_q;
    if (hc_step) begin
      hc_d = hc_wrap ? 7'd0 : hc_q + 7'd1;
    end
    if (hc_wrap) begin
      vc_d = (vc_q == VC_LAST) ? 9'd0 : vc_q + 9'd1;
    end
  end

  // Outputs decode the counter state before the edge, so they all carry the
  // same one-clock lag, including the exported counter copies.
  always_comb begin
    hc_w     = {1'b0, hc_q};
    vc_w     = {1'b0, vc_q};
    hclk_d   = ph_q[3];
    lclk_d   = (ph_q == 5'd31);
    hsync_d  = (hc_w >= HS_LO) && (hc_w < HS_HI);
    vsync_d  = (vc_w >= VS_LO) && (vc_w < VS_HI);
    de_d     = (hc_w < HD_END) && (vc_w < VD_END);
    fs_d     = (ph_q == 5'd0) && (hc_q == 7'd0) && (vc_q == 9'd0);
    hcount_d = hc_q;
    vcount_d = vc_q;
    if (hsync_d || vsync_d) begin
      video_d = 4'h0;
    end else if (de_d) begin
      video_d = bus.pixel_in;
    end else begin
      video_d = bus.border_color;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_q     <= 5'd0;
      hc_q     <= 7'd0;
      vc_q     <= 9'd0;
      hclk_q   <= 1'b0;
      lclk_q   <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      de_q     <= 1'b0;
      fs_q     <= 1'b0;
      hcount_q <= 7'd0;
      vcount_q <= 9'd0;
      video_q  <= 4'h0;
    end else begin
      ph_q     <= ph_d;
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      hclk_q   <= hclk_d;
      lclk_q   <= lclk_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      fs_q     <= fs_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      video_q  <= video_d;
    end
  end

  assign bus.hclk        = hclk_q;
  assign bus.lclk        = lclk_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync_l     = vsync_q;
  assign bus.display_en  = de_q;
  assign bus.frame_start = fs_q;
  assign bus.hcount      = hcount_q;
  assign bus.vcount      = vcount_q;
  assign bus.video       = video_q;

endmodule

// File: tb/tb_cga_timing_gen.sv
// Bench for cga_timing_gen: default geometry, a narrow-line variant and a
// tiny-frame variant so whole frames fit in a short run.
module tb_cga_timing_gen;

  // tiny-frame variant: 20 chars x 10 lines -> 320 clk/line, 3200 clk/frame
  localparam int C_HT = 20, C_HD = 12, C_HSS = 14, C_HSW = 3;
  localparam int C_VT = 10, C_VD = 6,  C_VSS = 7,  C_VSW = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pix;
  logic [3:0] bord;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cga_timing_if a_if ();
  cga_timing_if b_if ();
  cga_timing_if c_if ();

  assign a_if.pixel_in = pix;  assign a_if.border_color = bord;
  assign b_if.pixel_in = pix;  assign b_if.border_color = bord;
  assign c_if.pixel_in = pix;  assign c_if.border_color = bord;

  cga_timing_gen dut_a (.clk(clk), .reset(reset), .bus(a_if.master));

  cga_timing_gen #(.H_TOTAL(57), .H_DISP(40), .H_SYNC_START(45),
                   .H_SYNC_WIDTH(5)) dut_b (.clk(clk), .reset(reset), .bus(b_if.master));

  cga_timing_gen #(.H_TOTAL(C_HT), .H_DISP(C_HD), .H_SYNC_START(C_HSS),
                   .H_SYNC_WIDTH(C_HSW), .V_TOTAL(C_VT), .V_DISP(C_VD),
                   .V_SYNC_START(C_VSS), .V_SYNC_WIDTH(C_VSW))
    dut_c (.clk(clk), .reset(reset), .bus(c_if.master));

  initial begin
    if (!((90 + 10 <= 114) && (224 + 16 <= 262) && (45 + 5 <= 57) &&
          (C_HSS + C_HSW <= C_HT) && (C_VSS + C_VSW <= C_VT))) begin
      $display("FAIL param_window sync window exceeds total");
      $fatal(1);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] outs_a();
    return {a_if.hclk, a_if.lclk, a_if.hsync, a_if.vsync_l, a_if.display_en,
            a_if.frame_start, a_if.video, a_if.hcount, a_if.vcount};
  endfunction
  function automatic logic [25:0] outs_b();
    return {b_if.hclk, b_if.lclk, b_if.hsync, b_if.vsync_l, b_if.display_en,
            b_if.frame_start, b_if.video, b_if.hcount, b_if.vcount};
  endfunction
  function automatic logic [25:0] outs_c();
    return {c_if.hclk, c_if.lclk, c_if.hsync, c_if.vsync_l, c_if.display_en,
            c_if.frame_start, c_if.video, c_if.hcount, c_if.vcount};
  endfunction

  // Starts on the negedge at which reset was released; sample n is taken
  // on the negedge following the n-th rising edge after release.
  task automatic observe(input int ncyc);
    int hclk_first = 0, hclk_last = 0, hclk_len = 0, hclk_sp_bad = 0, hclk_w_bad = 0;
    int lclk_first = 0, lclk_last = 0, lclk_sp_bad = 0, lclk_w_bad = 0, lclk_nohclk = 0;
    int a_fs_cnt = 0, a_fs_first = 0, a_hc_max = 0, a_wrap_n = 0, a_hc_p = 0;
    int a_hs_first = 0, a_hs_rise = 0, a_hs_len = 0, a_hs_sp_bad = 0, a_hs_w_bad = 0;
    int vid_disp_bad = 0, vid_bord_bad = 0, vid_sync_bad = 0, de_bad = 0;
    int b_hs_first = 0, b_hs_rise = 0, b_hs_len = 0, b_hs_sp_bad = 0, b_hs_w_bad = 0;
    int c_fs_first = 0, c_fs_second = 0, c_wrap_bad = 0, c_vc_max = 0;
    int c_vs_first = 0, c_vs_len = 0, c_vs_w_bad = 0, c_vs_vc_bad = 0;
    int c_vs_vid_bad = 0, c_bord_bad = 0;
    logic hclk_p = 1'b0, lclk_p = 1'b0, a_hs_p = 1'b0, b_hs_p = 1'b0, c_vs_p = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("first_fs",     32'(a_if.frame_start), 32'd1);
        check("first_de",     32'(a_if.display_en),  32'd1);
        check("first_video",  32'(a_if.video),       32'hA);
        check("first_hcount", 32'(a_if.hcount),      32'd0);
        check("first_hclk",   32'(a_if.hclk),        32'd0);
      end
      // hclk / lclk strobes
      if (a_if.hclk && !hclk_p) begin
        if (hclk_first == 0) hclk_first = n;
        else if (n - hclk_last != 16) hclk_sp_bad++;
        hclk_last = n;
        hclk_len  = 0;
      end
      if (a_if.hclk) hclk_len++;
      if (!a_if.hclk && hclk_p && hclk_len != 8) hclk_w_bad++;
      if (a_if.lclk) begin
        if (lclk_p) lclk_w_bad++;
        if (!a_if.hclk) lclk_nohclk++;
        if (lclk_first == 0) lclk_first = n;
        else if (n - lclk_last != 32) lclk_sp_bad++;
        lclk_last = n;
      end
      // default geometry
      if (a_if.frame_start) begin
        a_fs_cnt++;
        if (a_fs_first == 0) a_fs_first = n;
      end
      if (int'(a_if.hcount) > a_hc_max) a_hc_max = int'(a_if.hcount);
      if (a_if.hcount == 7'd0 && a_hc_p != 0 && a_wrap_n == 0) a_wrap_n = n;
      a_hc_p = int'(a_if.hcount);
      if (a_if.hsync && !a_hs_p) begin
        if (a_hs_first == 0) a_hs_first = n;
        else if (n - a_hs_rise != 1824) a_hs_sp_bad++;
        a_hs_rise = n;
        a_hs_len  = 0;
      end
      if (a_if.hsync) a_hs_len++;
      if (!a_if.hsync && a_hs_p && a_hs_len != 160) a_hs_w_bad++;
      if (a_if.hsync) begin
        if (a_if.video != 4'h0) vid_sync_bad++;
      end else if (a_if.hcount < 7'd80) begin
        if (a_if.video != 4'hA) vid_disp_bad++;
      end
      if (a_if.hcount == 7'd85 && a_if.video != 4'h1) vid_bord_bad++;
      if (a_if.display_en != (a_if.hcount < 7'd80)) de_bad++;
      // narrow-line variant
      if (b_if.hsync && !b_hs_p) begin
        if (b_hs_first == 0) b_hs_first = n;
        else if (n - b_hs_rise != 912) b_hs_sp_bad++;
        b_hs_rise = n;
        b_hs_len  = 0;
      end
      if (b_if.hsync) b_hs_len++;
      if (!b_if.hsync && b_hs_p && b_hs_len != 80) b_hs_w_bad++;
      // tiny-frame variant
      if (c_if.frame_start) begin
        if (c_fs_first == 0) c_fs_first = n;
        else if (c_fs_second == 0) c_fs_second = n;
        if (c_if.hcount != 7'd0 || c_if.vcount != 9'd0) c_wrap_bad++;
      end
      if (int'(c_if.vcount) > c_vc_max) c_vc_max = int'(c_if.vcount);
      if (c_if.vsync_l && !c_vs_p) begin
        if (c_vs_first == 0) c_vs_first = n;
        c_vs_len = 0;
      end
      if (c_if.vsync_l) begin
        c_vs_len++;
        if (c_if.vcount != 9'd7 && c_if.vcount != 9'd8) c_vs_vc_bad++;
        if (c_if.video != 4'h0) c_vs_vid_bad++;
      end
      if (!c_if.vsync_l && c_vs_p && c_vs_len != 640) c_vs_w_bad++;
      if (!c_if.vsync_l && !c_if.hsync && c_if.vcount >= 9'd6 && c_if.video != 4'h1)
        c_bord_bad++;
      hclk_p = a_if.hclk;  lclk_p = a_if.lclk;
      a_hs_p = a_if.hsync; b_hs_p = b_if.hsync; c_vs_p = c_if.vsync_l;
    end
    check("hclk_first_rise", hclk_first, 9);
    check("hclk_period",     hclk_sp_bad, 0);
    check("hclk_duty",       hclk_w_bad, 0);
    check("lclk_first",      lclk_first, 32);
    check("lclk_spacing",    lclk_sp_bad, 0);
    check("lclk_width",      lclk_w_bad, 0);
    check("lclk_in_hclk",    lclk_nohclk, 0);
    check("a_fs_count",      a_fs_cnt, 1);
    check("a_fs_first",      a_fs_first, 1);
    check("a_hcount_max",    a_hc_max, 113);
    check("a_line_period",   a_wrap_n, 1825);
    check("a_hsync_rise",    a_hs_first, 1441);
    check("a_hsync_spacing", a_hs_sp_bad, 0);
    check("a_hsync_width",   a_hs_w_bad, 0);
    check("a_video_disp",    vid_disp_bad, 0);
    check("a_video_border",  vid_bord_bad, 0);
    check("a_video_hblank",  vid_sync_bad, 0);
    check("a_display_en",    de_bad, 0);
    check("b_hsync_rise",    b_hs_first, 721);
    check("b_line_period",   b_hs_sp_bad, 0);
    check("b_hsync_width",   b_hs_w_bad, 0);
    check("c_fs_first",      c_fs_first, 1);
    check("c_frame_period",  c_fs_second, 3201);
    check("c_wrap_together", c_wrap_bad, 0);
    check("c_vcount_max",    c_vc_max, 9);
    check("c_vsync_rise",    c_vs_first, 2241);
    check("c_vsync_width",   c_vs_w_bad, 0);
    check("c_vsync_lines",   c_vs_vc_bad, 0);
    check("c_video_vblank",  c_vs_vid_bad, 0);
    check("c_video_vborder", c_bord_bad, 0);
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    pix   = 4'hA;
    bord  = 4'h1;
    repeat (4) @(negedge clk);
    check("rst_hold_a", 32'(outs_a()), 32'd0);
    check("rst_hold_b", 32'(outs_b()), 32'd0);
    check("rst_hold_c", 32'(outs_c()), 32'd0);
    reset = 1'b0;
    observe(10000);

    // pixel_in changes reach video one clock later
    guard = 0;
    @(negedge clk);
    while (!(a_if.display_en && a_if.hcount < 7'd70) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("wait_display", 32'(guard < 2000), 32'd1);
    pix = 4'h5;
    #1;
    check("pix_not_early", 32'(a_if.video), 32'hA);
    @(negedge clk);
    check("pix_5_latency", 32'(a_if.video), 32'h5);
    pix = 4'hC;
    @(negedge clk);
    check("pix_c_latency", 32'(a_if.video), 32'hC);
    pix = 4'hA;

    // asynchronous reset in the middle of the tiny frame
    guard = 0;
    @(negedge clk);
    while (!(c_if.hcount == 7'd8 && c_if.vcount == 9'd5) && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check("wait_midframe", 32'(guard < 4000), 32'd1);
    check("midframe_de", 32'(c_if.display_en), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_a", 32'(outs_a()), 32'd0);
    check("async_rst_b", 32'(outs_b()), 32'd0);
    check("async_rst_c", 32'(outs_c()), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_hold_mid_c", 32'(outs_c()), 32'd0);
    reset = 1'b0;
    observe(3300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
